dru_word_assembler: RTL and testbench

DRU_WORD_ASSEMBLER -- requirements
Module: dru_word_assembler

---
 rtl/dru_word_assembler.sv | 128 ++++++++++++
 tb/tb_dru_word_assembler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dru_word_assembler.sv
// Packs 0..3 recovered bits per cycle into 10-bit words (earliest bit in bit 0).
// Define DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN to build in the K28.5 comma aligner with bit slipping.
module dru_word_assembler #(
  parameter int WORD_W = 10
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [2:0]        in_bits,
  input  logic [1:0]        in_cnt,
  input  logic              realign,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              aligned,
  output logic [3:0]        slip_cnt
);

  localparam int ACC_W = WORD_W + 2;

  // Output handshake: word_valid is a one-cycle strobe with no backpressure; word_out
  // is meaningful only while word_valid is high and otherwise holds the previous word.
  logic [ACC_W-1:0]  acc_buf, acc_app, acc_rem, acc_nxt;
  logic [3:0]        fill, fill_app, fill_rem, fill_nxt;
  logic [2:0]        eff_bits, bit_mask;
  logic [1:0]        eff_cnt;
  logic              have_word, emit, drop_first;
  logic [WORD_W-1:0] cand;

  always_comb begin
    eff_bits = drop_first ? {1'b0, in_bits[2:1]} : in_bits;
    eff_cnt  = drop_first ? in_cnt - 2'd1 : in_cnt;
    case (eff_cnt)
      2'd0:    bit_mask = 3'b000;
      2'd1:    bit_mask = 3'b001;
      2'd2:    bit_mask = 3'b011;
      default: bit_mask = 3'b111;
    endcase
    acc_app   = acc_buf | (ACC_W'(eff_bits & bit_mask) << fill);
    fill_app  = fill + {2'b00, eff_cnt};
    have_word = fill_app >= 4'(WORD_W);
    cand      = acc_app[WORD_W-1:0];
    acc_rem   = have_word ? (acc_app >> WORD_W) : acc_app;
    fill_rem  = have_word ? (fill_app - 4'(WORD_W)) : fill_app;
  end

`ifdef DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN
  localparam logic [WORD_W-1:0] COMMA_NEG = 10'h17C;
  localparam logic [WORD_W-1:0] COMMA_POS = 10'h283;

  logic       slip_pending, pending_nxt, aligned_nxt, lock, slip, is_comma;
  logic [3:0] slip_cnt_nxt;

  // A slip owed while the buffer was empty eats the first bit of the next non-empty cycle.
  assign drop_first = slip_pending && (in_cnt != 2'd0);

  always_comb begin
    is_comma    = (cand == COMMA_NEG) || (cand == COMMA_POS);
    emit        = 1'b0;
    lock        = 1'b0;
    slip        = 1'b0;
    acc_nxt     = acc_rem;
    fill_nxt    = fill_rem;
    pending_nxt = drop_first ? 1'b0 : slip_pending;
    // Realign wins: the candidate word is consumed but neither emitted nor used to lock.
    if (have_word && !realign) begin
      if (aligned) begin
        emit = 1'b1;
      end else if (is_comma) begin
        lock = 1'b1;
        emit = 1'b1;
      end else begin
        slip = 1'b1;
      end
    end
    if (slip) begin
      if (fill_rem != 4'd0) begin
        acc_nxt  = acc_rem >> 1;
        fill_nxt = fill_rem - 4'd1;
      end else begin
        pending_nxt = 1'b1;
      end
    end
    aligned_nxt  = aligned | lock;
    slip_cnt_nxt = (slip && slip_cnt != 4'd15) ? slip_cnt + 4'd1 : slip_cnt;
    if (realign) begin
      pending_nxt  = 1'b0;
      aligned_nxt  = 1'b0;
      slip_cnt_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      slip_pending <= 1'b0;
      aligned      <= 1'b0;
      slip_cnt     <= 4'd0;
    end else begin
      slip_pending <= pending_nxt;
      aligned      <= aligned_nxt;
      slip_cnt     <= slip_cnt_nxt;
    end
  end
`else
  logic unused_realign;

  assign unused_realign = realign;
  assign drop_first     = 1'b0;
  assign emit           = have_word;
  assign acc_nxt        = acc_rem;
  assign fill_nxt       = fill_rem;
  assign aligned        = 1'b1;
  assign slip_cnt       = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc_buf    <= '0;
      fill       <= 4'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      acc_buf    <= acc_nxt;
      fill       <= fill_nxt;
      word_valid <= emit;
      if (emit) word_out <= cand;
    end
  end

endmodule

// File: tb/tb_dru_word_assembler.sv
// Bench for dru_word_assembler: bit-queue reference model feeding an expected-word scoreboard.
// Comma-aligner scenarios are built when DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN is defined.
module tb_dru_word_assembler;

`ifdef DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [2:0] in_bits = 3'b000;
  logic [1:0] in_cnt = 2'd0;
  logic       realign = 1'b0;
  logic [9:0] word_out;
  logic       word_valid;
  logic       aligned;
  logic [3:0] slip_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];
  bit         m_bits[$];
  bit         m_aligned = 1'b0;
  bit         m_pending = 1'b0;
  int         m_slip_cnt = 0;

  always #5 clk = ~clk;

  dru_word_assembler #(.WORD_W(10)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_bits    (in_bits),
    .in_cnt     (in_cnt),
    .realign    (realign),
    .word_out   (word_out),
    .word_valid (word_valid),
    .aligned    (aligned),
    .slip_cnt   (slip_cnt)
  );

  // Reference: bit-serial queue; a word is judged once ten bits have arrived in a cycle.
  task automatic model_step(input logic [2:0] b, input int c, input bit rl);
    logic [9:0] w;
    for (int i = 0; i < c; i++) begin
      if (m_pending) m_pending = 1'b0;
      else m_bits.push_back(b[i]);
    end
    if (m_bits.size() >= 10) begin
      w = '0;
      for (int k = 0; k < 10; k++) w[k] = m_bits.pop_front();
      if (!ALIGN_EN) begin
        exp_q.push_back(w);
      end else if (!rl) begin
        if (m_aligned) begin
          exp_q.push_back(w);
        end else if (w == 10'h17C || w == 10'h283) begin
          m_aligned = 1'b1;
          exp_q.push_back(w);
        end else begin
          if (m_bits.size() > 0) void'(m_bits.pop_front());
          else m_pending = 1'b1;
          if (m_slip_cnt < 15) m_slip_cnt++;
        end
      end
    end
    if (ALIGN_EN && rl) begin
      m_aligned  = 1'b0;
      m_pending  = 1'b0;
      m_slip_cnt = 0;
    end
  endtask

  task automatic drive(input logic [2:0] b, input int c, input bit rl);
    in_bits = b;
    in_cnt  = c[1:0];
    realign = rl;
    @(posedge clk);
    if (aresetn) model_step(b, c, rl);
    #1;
    in_cnt  = 2'd0;
    realign = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (aresetn) begin
      if (word_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected: got word_out=%h with no word expected", word_out);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (word_out !== e) begin
            n_fail++;
            $display("FAIL word_data: got %h expected %h", word_out, e);
          end
        end
      end
      n_tests++;
      if (aligned !== m_aligned || slip_cnt !== 4'(m_slip_cnt)) begin
        n_fail++;
        $display("FAIL status: got aligned=%b slip_cnt=%0d expected aligned=%b slip_cnt=%0d",
                 aligned, slip_cnt, m_aligned, m_slip_cnt);
      end
    end
  end

  task automatic apply_reset(input bit check);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL words_missing: %0d expected words never appeared, required 0", exp_q.size());
    end
    exp_q.delete();
    aresetn = 1'b0;
    in_cnt  = 2'd0;
    realign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      n_tests++;
      if (word_out !== 10'h000 || word_valid !== 1'b0 || aligned !== !ALIGN_EN || slip_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got word_out=%h valid=%b aligned=%b slip_cnt=%0d required 000/0/%b/0",
                 word_out, word_valid, aligned, slip_cnt, !ALIGN_EN);
      end
    end
    m_bits.delete();
    m_aligned  = !ALIGN_EN;
    m_pending  = 1'b0;
    m_slip_cnt = 0;
    aresetn = 1'b1;
  endtask

  task automatic check_valid(input string name, input logic exp_v, input logic [9:0] exp_w);
    n_tests++;
    if (word_valid !== exp_v || (exp_v && word_out !== exp_w)) begin
      n_fail++;
      $display("FAIL %s: got valid=%b word=%h required valid=%b word=%h", name, word_valid, word_out, exp_v, exp_w);
    end
  endtask

  task automatic drive_comma(input logic [9:0] c);
    drive(c[2:0], 3, 1'b0);
    drive(c[5:3], 3, 1'b0);
    drive(c[8:6], 3, 1'b0);
    drive({2'($urandom), c[9]}, 1, 1'b0);
  endtask

  task automatic test_reset;
    apply_reset(1'b1);
  endtask

`ifndef DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN
  task automatic test_alternating;
    apply_reset(1'b0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive({1'($urandom), 2'b01}, 2, 1'b0);
      check_valid("alternating", (cyc % 5) == 4, 10'h155);
    end
  endtask
`endif

  task automatic test_partial_counts;
    logic [9:0] c;
    c = 10'h17C;
    apply_reset(1'b0);
    drive(c[2:0], 3, 1'b0);  check_valid("partial_c0", 1'b0, 10'h000);
    drive(c[5:3], 3, 1'b0);  check_valid("partial_c1", 1'b0, 10'h000);
    drive(c[8:6], 3, 1'b0);  check_valid("partial_c2", 1'b0, 10'h000);
    drive(3'($urandom), 0, 1'b0); check_valid("partial_c3", 1'b0, 10'h000);
    drive({2'($urandom), c[9]}, 1, 1'b0); check_valid("partial_c4", 1'b1, c);
    drive(c[2:0], 3, 1'b0);  check_valid("fill_zero_a", 1'b0, 10'h000);
    drive(c[5:3], 3, 1'b0);  check_valid("fill_zero_b", 1'b0, 10'h000);
    drive(c[8:6], 3, 1'b0);  check_valid("fill_zero_c", 1'b0, 10'h000);
    drive({2'($urandom), c[9]}, 1, 1'b0); check_valid("fill_zero_d", 1'b1, c);
  endtask

  task automatic test_random_stream;
    apply_reset(1'b0);
    for (int cyc = 0; cyc < 300; cyc++)
      drive(3'($urandom), $urandom_range(0, 3), $urandom_range(0, 40) == 0);
    repeat (2) drive(3'b000, 0, 1'b0);
  endtask

`ifdef DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN
  task automatic test_slip_lock;
    logic [9:0] c;
    logic [2:0] b;
    bit seen;
    c = 10'h17C;
    seen = 1'b0;
    apply_reset(1'b0);
    // Stream is the comma repeated, shifted so the first comma starts at bit 3.
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      for (int k = 0; k < 3; k++) b[k] = c[(3 * cyc + k + 7) % 10];
      drive(b, 3, 1'b0);
      if (word_valid) begin
        seen = 1'b1;
        n_tests++;
        if (word_out !== 10'h17C || slip_cnt !== 4'd3 || aligned !== 1'b1) begin
          n_fail++;
          $display("FAIL slip_lock: got word=%h slip_cnt=%0d aligned=%b required 17c/3/1", word_out, slip_cnt, aligned);
        end
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL slip_lock_timeout: got no word in 30 cycles, required a locked comma word");
    end
  endtask

  task automatic test_realign;
    logic [9:0] c;
    c = 10'h17C;
    apply_reset(1'b0);
    for (int cyc = 0; cyc < 15; cyc++) begin
      drive({1'b0, c[(2 * cyc + 1) % 10], c[(2 * cyc) % 10]}, 2, cyc == 9);
      check_valid("realign_valid", cyc == 4 || cyc == 14, c);
      n_tests++;
      if (aligned !== (cyc >= 4 && cyc < 9) && aligned !== (cyc >= 14)) begin
        n_fail++;
        $display("FAIL realign_aligned: cycle %0d got aligned=%b", cyc, aligned);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_word;
    apply_reset(1'b0);
    drive_comma(10'h17C);
    check_valid("pre_reset_word", 1'b1, 10'h17C);
    drive(3'b111, 3, 1'b0);
    drive(3'b111, 3, 1'b0);
    drive(3'b111, 1, 1'b0);
    apply_reset(1'b1);
    drive_comma(10'h17C);
    check_valid("post_reset_word", 1'b1, 10'h17C);
  endtask

  initial begin
    test_reset();
`ifndef DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN
    test_alternating();
`endif
    test_partial_counts();
`ifdef DRU_WORD_ASSEMBLER_COMMA_ALIGN_EN
    test_slip_lock();
    test_realign();
`endif
    test_reset_mid_word();
    test_random_stream();
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d expected words outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
